// File: rtl/sram_bank_be.sv
// Single-bank SRAM with byte-masked write, write-first read forwarding,
// optional output register and a hardware zero-initialisation sweep.
module sram_bank_be #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  EN_M,
  input  logic [ADDR_W-1:0]     ADDR,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     ADDR_WRITE,
  input  logic [DATA_W-1:0]     DIN,
  input  logic [DATA_W/8-1:0]   WMASK,
  output logic [DATA_W-1:0]     DOUT,
  output logic                  DOUT_VALID,
  output logic                  INIT_DONE
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                rd_q;
  logic                pw_valid_q;
  logic [ADDR_W-1:0]   pw_addr_q;
  logic [DATA_W-1:0]   pw_data_q;
  logic [NB-1:0]       pw_mask_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_word;

  logic restart;
  logic run;
  logic wr_accept;
  logic rd_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  assign restart   = RST | CLR;
  assign run       = (state_q == ST_RUN);
  assign wr_accept = run & ~restart & WE & in_range(ADDR_WRITE);
  assign rd_accept = run & ~restart & EN_M;
  assign INIT_DONE = run;

  // Control FSM: init sweep counter, read-address hold, pending-write and read-valid flags
  always_ff @(posedge CLK) begin
    if (restart) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      raddr_q    <= '0;
      rd_q       <= 1'b0;
      pw_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= ST_RUN;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      pw_valid_q <= wr_accept;
      rd_q       <= rd_accept;
      if (rd_accept) begin
        raddr_q <= ADDR;
      end
    end
  end

  // Pending-write payload; only meaningful while pw_valid_q is set
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      pw_addr_q <= ADDR_WRITE;
      pw_data_q <= DIN;
      pw_mask_q <= WMASK;
    end
  end

  // Array update: zero sweep during init, masked commit of the pending write in run
  always_ff @(posedge CLK) begin
    if (!restart) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (pw_valid_q) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (pw_mask_q[b]) begin
            mem_q[pw_addr_q][8*b +: 8] <= pw_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Logical contents of the held address: array merged per byte with the pending write
  always_comb begin
    rd_word = '0;
    if (in_range(raddr_q)) begin
      rd_word = mem_q[raddr_q];
      if (pw_valid_q && (pw_addr_q == raddr_q)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (pw_mask_q[b]) begin
            rd_word[8*b +: 8] = pw_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_comb_out
      assign DOUT       = run ? rd_word : '0;
      assign DOUT_VALID = rd_q;
    end else begin : g_reg_out
      logic [DATA_W-1:0] dout_q;
      logic              dv_q;

      // Extra output stage: latch the word one cycle after the read is accepted, hold between reads
      always_ff @(posedge CLK) begin
        if (restart) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_q;
          if (rd_q) begin
            dout_q <= rd_word;
          end
        end
      end

      assign DOUT       = dout_q;
      assign DOUT_VALID = dv_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_bank_be.sv
// Self-checking bench for sram_bank_be: three instances share stimulus
// (DEPTH=128/OUT_REG=0, DEPTH=128/OUT_REG=1, DEPTH=100/OUT_REG=0).
module tb_sram_bank_be;

  logic         CLK = 1'b0;
  logic         RST, CLR, EN_M, WE;
  logic [6:0]   ADDR, ADDR_WRITE;
  logic [511:0] DIN;
  logic [63:0]  WMASK;

  logic [511:0] dout0, dout1, dout2;
  logic         dv0, dv1, dv2, done0, done1, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sram_bank_be #(.DATA_W(512), .DEPTH(128), .ADDR_W(7), .OUT_REG(0)) u0 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN_M(EN_M), .ADDR(ADDR), .WE(WE),
    .ADDR_WRITE(ADDR_WRITE), .DIN(DIN), .WMASK(WMASK),
    .DOUT(dout0), .DOUT_VALID(dv0), .INIT_DONE(done0));

  sram_bank_be #(.DATA_W(512), .DEPTH(128), .ADDR_W(7), .OUT_REG(1)) u1 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN_M(EN_M), .ADDR(ADDR), .WE(WE),
    .ADDR_WRITE(ADDR_WRITE), .DIN(DIN), .WMASK(WMASK),
    .DOUT(dout1), .DOUT_VALID(dv1), .INIT_DONE(done1));

  sram_bank_be #(.DATA_W(512), .DEPTH(100), .ADDR_W(7), .OUT_REG(0)) u2 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN_M(EN_M), .ADDR(ADDR), .WE(WE),
    .ADDR_WRITE(ADDR_WRITE), .DIN(DIN), .WMASK(WMASK),
    .DOUT(dout2), .DOUT_VALID(dv2), .INIT_DONE(done2));

  // Reference model: memory contents as seen after every write sampled so far
  int unsigned  dep [3] = '{128, 128, 100};
  logic [511:0] mdl [3][128];
  logic [6:0]   held;
  logic         exp0_valid;
  logic         exp1_valid;
  logic [511:0] exp1_dout;
  logic         rd_prev;
  logic [511:0] rd_prev_val;

  function automatic logic [511:0] mread(input int i, input logic [6:0] a);
    if (int'(a) < int'(dep[i])) return mdl[i][a];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 128; a++)
        mdl[i][a] = '0;
    held        = '0;
    exp0_valid  = 1'b0;
    exp1_valid  = 1'b0;
    exp1_dout   = '0;
    rd_prev     = 1'b0;
    rd_prev_val = '0;
  endtask

  // One clock of stimulus; the model is advanced at the sampling edge
  task automatic drive(input logic we, input logic [6:0] wa, input logic [511:0] d,
                       input logic [63:0] m, input logic en, input logic [6:0] ra,
                       input logic clr);
    WE = we; ADDR_WRITE = wa; DIN = d; WMASK = m; EN_M = en; ADDR = ra; CLR = clr;
    @(posedge CLK);
    if (clr) begin
      model_clear();
    end else begin
      exp1_valid = rd_prev;
      if (rd_prev) exp1_dout = rd_prev_val;
      if (we) begin
        for (int i = 0; i < 3; i++)
          if (int'(wa) < int'(dep[i]))
            for (int b = 0; b < 64; b++)
              if (m[b]) mdl[i][wa][8*b +: 8] = d[8*b +: 8];
      end
      if (en) held = ra;
      rd_prev = en;
      if (en) rd_prev_val = mread(1, ra);
      exp0_valid = en;
    end
    #1;
    WE = 1'b0; EN_M = 1'b0; CLR = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, '0, '0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_reset();
    int t0, t1, t2;
    logic [6:0] ra;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    model_clear();
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b expected 0", done0); end
    n_cmp++; if ({dv0, dv1, dv2} !== 3'b000) begin n_bad++; $display("FAIL rst_valid: got %b expected 000", {dv0, dv1, dv2}); end
    n_cmp++; if (dout0 !== '0) begin n_bad++; $display("FAIL rst_dout0: got %h expected 0", dout0); end
    n_cmp++; if (dout1 !== '0) begin n_bad++; $display("FAIL rst_dout1: got %h expected 0", dout1); end
    RST = 1'b0;
    t0 = 0; t1 = 0; t2 = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CLK);
      #1;
      if (done0 && t0 == 0) t0 = n;
      if (done1 && t1 == 0) t1 = n;
      if (done2 && t2 == 0) t2 = n;
      if (t0 != 0 && t1 != 0 && t2 != 0) break;
    end
    n_cmp++; if (t0 !== 128) begin n_bad++; $display("FAIL init_len0: got %0d expected 128", t0); end
    n_cmp++; if (t1 !== 128) begin n_bad++; $display("FAIL init_len1: got %0d expected 128", t1); end
    n_cmp++; if (t2 !== 100) begin n_bad++; $display("FAIL init_len2: got %0d expected 100", t2); end
    for (int k = 0; k < 3; k++) begin
      ra = (k == 0) ? 7'd0 : (k == 1) ? 7'd64 : 7'd127;
      drive(1'b0, 7'd0, '0, '0, 1'b1, ra, 1'b0);
      n_cmp++; if (dv0 !== 1'b1) begin n_bad++; $display("FAIL init_rd_valid a=%0d: got %b expected 1", ra, dv0); end
      n_cmp++; if (dout0 !== '0) begin n_bad++; $display("FAIL init_rd0 a=%0d: got %h expected 0", ra, dout0); end
      n_cmp++; if (dout2 !== '0) begin n_bad++; $display("FAIL init_rd2 a=%0d: got %h expected 0", ra, dout2); end
    end
    idle();
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== '0) begin n_bad++; $display("FAIL init_rd1: got v=%b %h expected v=1 0", dv1, dout1); end
  endtask

  task automatic test_masked_write();
    logic [511:0] expv;
    expv = '1;
    expv[7:0] = 8'h00;
    drive(1'b1, 7'd5, '1, '1, 1'b0, 7'd0, 1'b0);
    drive(1'b1, 7'd5, '0, 64'h1, 1'b0, 7'd0, 1'b0);
    drive(1'b0, 7'd0, '0, '0, 1'b1, 7'd5, 1'b0);
    n_cmp++; if (dv0 !== 1'b1 || dout0 !== expv) begin n_bad++; $display("FAIL mask_rd0: got v=%b %h expected v=1 %h", dv0, dout0, expv); end
    idle();
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== expv) begin n_bad++; $display("FAIL mask_rd1: got v=%b %h expected v=1 %h", dv1, dout1, expv); end
  endtask

  task automatic test_forward();
    logic [511:0] pat;
    pat = {64{8'hA5}};
    drive(1'b1, 7'd9, pat, '1, 1'b1, 7'd9, 1'b0);
    n_cmp++; if (dv0 !== 1'b1 || dout0 !== pat) begin n_bad++; $display("FAIL fwd_rd0: got v=%b %h expected v=1 %h", dv0, dout0, pat); end
    n_cmp++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL fwd_early1: got %b expected 0", dv1); end
    idle();
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== pat) begin n_bad++; $display("FAIL fwd_rd1: got v=%b %h expected v=1 %h", dv1, dout1, pat); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL fwd_pulse0: got %b expected 0", dv0); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] x3, x4;
    x3 = {16{32'h3333_C0DE}};
    x4 = {16{32'h4444_BEEF}};
    drive(1'b1, 7'd3, x3, '1, 1'b0, 7'd0, 1'b0);
    drive(1'b1, 7'd4, x4, '1, 1'b1, 7'd3, 1'b0);
    n_cmp++; if (dv0 !== 1'b1 || dout0 !== x3) begin n_bad++; $display("FAIL b2b_rd3: got v=%b %h expected v=1 %h", dv0, dout0, x3); end
    drive(1'b0, 7'd0, '0, '0, 1'b1, 7'd4, 1'b0);
    n_cmp++; if (dout0 !== x4) begin n_bad++; $display("FAIL b2b_rd4: got %h expected %h", dout0, x4); end
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== x3) begin n_bad++; $display("FAIL b2b_rd3_reg: got v=%b %h expected v=1 %h", dv1, dout1, x3); end
    idle();
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== x4) begin n_bad++; $display("FAIL b2b_rd4_reg: got v=%b %h expected v=1 %h", dv1, dout1, x4); end
  endtask

  task automatic test_boundary();
    logic [511:0] pat;
    pat = {8{64'h0123_4567_89AB_CDEF}};
    drive(1'b1, 7'd100, '1, '1, 1'b0, 7'd0, 1'b0);
    drive(1'b1, 7'd99, pat, '1, 1'b0, 7'd0, 1'b0);
    drive(1'b0, 7'd0, '0, '0, 1'b1, 7'd100, 1'b0);
    n_cmp++; if (dv2 !== 1'b1 || dout2 !== '0) begin n_bad++; $display("FAIL oob_rd100: got v=%b %h expected v=1 0", dv2, dout2); end
    n_cmp++; if (dout0 !== '1) begin n_bad++; $display("FAIL inr_rd100: got %h expected all ones", dout0); end
    drive(1'b0, 7'd0, '0, '0, 1'b1, 7'd99, 1'b0);
    n_cmp++; if (dv2 !== 1'b1 || dout2 !== pat) begin n_bad++; $display("FAIL rd99: got v=%b %h expected v=1 %h", dv2, dout2, pat); end
    drive(1'b0, 7'd0, '0, '0, 1'b1, 7'd127, 1'b0);
    n_cmp++; if (dv2 !== 1'b1 || dout2 !== '0) begin n_bad++; $display("FAIL oob_rd127: got v=%b %h expected v=1 0", dv2, dout2); end
  endtask

  task automatic test_random();
    logic         we, en;
    logic [6:0]   wa, ra;
    logic [511:0] d;
    logic [63:0]  m;
    int           sel;
    for (int it = 0; it < 400; it++) begin
      we = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(95, 105)) : 7'($urandom_range(0, 5));
      ra = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(95, 105)) : 7'($urandom_range(0, 5));
      for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
      m = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) m = '0;
      if (sel == 1) m = '1;
      drive(we, wa, d, m, en, ra, 1'b0);
      n_cmp++; if (dv0 !== exp0_valid) begin n_bad++; $display("FAIL rnd_v0 it=%0d: got %b expected %b", it, dv0, exp0_valid); end
      n_cmp++; if (dout0 !== mread(0, held)) begin n_bad++; $display("FAIL rnd_d0 it=%0d: got %h expected %h", it, dout0, mread(0, held)); end
      n_cmp++; if (dv2 !== exp0_valid) begin n_bad++; $display("FAIL rnd_v2 it=%0d: got %b expected %b", it, dv2, exp0_valid); end
      n_cmp++; if (dout2 !== mread(2, held)) begin n_bad++; $display("FAIL rnd_d2 it=%0d: got %h expected %h", it, dout2, mread(2, held)); end
      n_cmp++; if (dv1 !== exp1_valid) begin n_bad++; $display("FAIL rnd_v1 it=%0d: got %b expected %b", it, dv1, exp1_valid); end
      n_cmp++; if (dout1 !== exp1_dout) begin n_bad++; $display("FAIL rnd_d1 it=%0d: got %h expected %h", it, dout1, exp1_dout); end
    end
  endtask

  task automatic test_clr();
    int t0, t2;
    drive(1'b1, 7'd10, '1, '1, 1'b1, 7'd10, 1'b0);
    drive(1'b0, 7'd0, '0, '0, 1'b0, 7'd0, 1'b1);
    n_cmp++; if ({dv0, dv1, dv2} !== 3'b000) begin n_bad++; $display("FAIL clr_valid: got %b expected 000", {dv0, dv1, dv2}); end
    n_cmp++; if (dout0 !== '0 || dout1 !== '0 || dout2 !== '0) begin n_bad++; $display("FAIL clr_dout: got %h / %h expected 0", dout0, dout1); end
    n_cmp++; if ({done0, done1, done2} !== 3'b000) begin n_bad++; $display("FAIL clr_done: got %b expected 000", {done0, done1, done2}); end
    t0 = 0; t2 = 0;
    for (int n = 1; n <= 200; n++) begin
      WE = (n < 99); EN_M = (n < 99);
      ADDR = 7'($urandom_range(0, 127)); ADDR_WRITE = 7'($urandom_range(0, 127));
      DIN = '1; WMASK = '1;
      @(posedge CLK);
      #1;
      n_cmp++; if ({dv0, dv1, dv2} !== 3'b000) begin n_bad++; $display("FAIL init_valid n=%0d: got %b expected 000", n, {dv0, dv1, dv2}); end
      if (done0 && t0 == 0) t0 = n;
      if (done2 && t2 == 0) t2 = n;
      if (t0 != 0) break;
    end
    WE = 1'b0; EN_M = 1'b0;
    n_cmp++; if (t0 !== 128) begin n_bad++; $display("FAIL clr_len0: got %0d expected 128", t0); end
    n_cmp++; if (t2 !== 100) begin n_bad++; $display("FAIL clr_len2: got %0d expected 100", t2); end
    for (int a = 0; a < 128; a++) begin
      drive(1'b0, 7'd0, '0, '0, 1'b1, 7'(a), 1'b0);
      n_cmp++; if (dv0 !== 1'b1 || dout0 !== '0) begin n_bad++; $display("FAIL clr_rd0 a=%0d: got v=%b %h expected v=1 0", a, dv0, dout0); end
      n_cmp++; if (dout2 !== '0) begin n_bad++; $display("FAIL clr_rd2 a=%0d: got %h expected 0", a, dout2); end
    end
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; EN_M = 1'b0; WE = 1'b0;
    ADDR = '0; ADDR_WRITE = '0; DIN = '0; WMASK = '0;
    model_clear();
    test_reset();
    test_masked_write();
    test_forward();
    test_back_to_back();
    test_boundary();
    test_random();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/sram_bank_be.md
Name: sram_bank_be

Overview:
- Parametrised successor of the team's single-bank weight/state SRAM for the LSTM datapath.
- Keeps the familiar timing: separate read and write addresses, write request captured then committed one cycle later, read address captured on EN_M.
- Adds generic width/depth, per-byte write mask, coherent read-during-pending-write forwarding, optional output register, synchronous reset and a hardware zero-initialisation sweep (also runtime-triggerable), plus read-valid/ready status.

Parameters:
- DATA_W, 512, word width in bits; must be a multiple of 8.
- DEPTH, 128, number of words; need not be a power of 2.
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH.
- OUT_REG, 0, 0 = DOUT driven from the held address; 1 = one extra registered output stage.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CLR  in  1  single-cycle pulse; restarts the zero-init sweep.
- EN_M  in  1  read enable; captures ADDR.
- ADDR  in  ADDR_W  read address.
- WE  in  1  write request.
- ADDR_WRITE  in  ADDR_W  write address.
- DIN  in  DATA_W  write data.
- WMASK  in  DATA_W/8  byte enables; bit i covers DIN[8i+7:8i].
- DOUT  out  DATA_W  read data.
- DOUT_VALID  out  1  one-cycle pulse per completed read.
- INIT_DONE  out  1  high when the array is usable.

Behaviour:
- Clock/reset: one clock (CLK); reset RST is synchronous and active-high.
- FSM states:
  - INIT: entered on RST or CLR. A counter starts at 0 and writes all-zero to mem[cnt] each cycle, incrementing until cnt == DEPTH-1. After that edge the FSM moves to RUN. INIT lasts exactly DEPTH cycles.
  - RUN: normal operation. INIT_DONE=1 only in RUN.
- Reset values: INIT_DONE=0, DOUT_VALID=0, DOUT=0, held read address=0, pending-write valid=0, init counter=0.
- While in INIT:
  - WE and EN_M are ignored.
  - DOUT_VALID stays 0 and DOUT stays 0.
- Write path (RUN):
  - Edge N samples WE=1 into a pending stage (addr, data, mask).
  - Edge N+1 merges the pending data into mem[addr]. Only bytes with mask bit=1 are updated; others are unchanged.
  - Back-to-back writes are accepted every cycle.
  - A write to an address >= DEPTH is dropped silently.
  - WE with WMASK=0 is a legal no-op.
- Read path (RUN):
  - Edge N samples EN_M=1 and holds ADDR until the next accepted read.
  - OUT_REG=0: DOUT is valid in cycle N+1 and DOUT_VALID=1 in cycle N+1.
  - OUT_REG=1: DOUT is valid in cycle N+2, DOUT_VALID is delayed to match, and DOUT holds between reads.
  - OUT_REG=0 only: DOUT continuously tracks the logical contents of the held address, so later writes become visible.
- Coherence:
  - Logical contents = array merged with the pending write when addresses match.
  - A read sampled at edge N returns every write sampled at edges <= N, including a write sampled at the same edge N (write-first).
  - No stale data is returned; forwarding applies the pending mask per byte.
- Out-of-range read (ADDR >= DEPTH): DOUT=0, DOUT_VALID still pulses.
- CLR or RST asserted mid-operation:
  - Any pending write is discarded.
  - An in-flight read's DOUT_VALID is suppressed and DOUT is forced to 0.
  - The sweep restarts at 0.
- CLR asserted during INIT restarts the counter at 0.
- RST has priority over CLR.
- Simultaneous WE and EN_M at the same or different addresses are both accepted in the same cycle.

Test Plan:
1. Init sweep (DEPTH=128): deassert RST → INIT_DONE rises exactly 128 cycles later; reads of addresses 0, 64 and 127 return 0.
2. Masked write: write 0xFF..FF with full mask to addr 5, then write 0x00..00 with WMASK=0x0001 → read of addr 5 returns all-ones except byte 0 = 0x00.
3. Forwarding: at the same edge, WE (addr 9, DIN=0xA5 pattern) and EN_M (ADDR 9) → DOUT=0xA5 pattern with DOUT_VALID in the next cycle, under both OUT_REG=0 and OUT_REG=1 (with the extra cycle of latency).
4. Back-to-back writes (addr 3 then addr 4) with a read of addr 3 in the cycle of the second write → each value committed and correct; no stale read.
5. Boundaries (DEPTH=100, ADDR_W=7): write to addr 100 is dropped; read of addr 100 → DOUT=0 with DOUT_VALID=1; read of addr 99 returns its written data.
6. CLR mid-traffic: pulse CLR with a write pending → no DOUT_VALID, INIT_DONE low for DEPTH cycles, and afterwards every address reads 0.
